i2s_capture: RTL and testbench
==============================

I2S_CAPTURE -- requirements
Module: i2s_capture

Interface
REQ-001 SHALL have parameter CLK_DIV, default 16: clk cycles per i2s_clk period; even, at least 4.
REQ-002 SHALL have parameter SLOT_BITS, default 32: i2s_clk cycles per channel slot.
REQ-003 SHALL have parameter DATA_SIZE, default 24: valid MSB-first bits per slot; at most SLOT_BITS.
REQ-004 SHALL have parameter REDUCE_FACTOR, default 2: most-significant bytes kept per sample; 1 to DATA_SIZE/8.
REQ-005 SHALL have parameter CHANNELS, default 2: 1 captures left only, 2 captures left then right.
REQ-006 SHALL have parameter DECIMATE, default 1: pass one frame of every DECIMATE frames.
REQ-007 SHALL have port clk, input, 1 bit: system clock; single clock domain.
REQ-008 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-009 SHALL have port enable, input, 1 bit: capture enable.
REQ-010 SHALL have port i2s_clk, output, 1 bit: I2S bit clock.
REQ-011 SHALL have port i2s_ws, output, 1 bit: I2S word select.
REQ-012 SHALL have port i2s_sd, input, 1 bit: I2S serial data.
REQ-013 SHALL have port out_data, output, 8 bits: byte stream.
REQ-014 SHALL have port out_valid, output, 1 bit: out_data valid.
REQ-015 SHALL have port out_ready, input, 1 bit: downstream accepts the byte.
REQ-016 SHALL have port out_last, output, 1 bit: marks the final byte of a frame.
REQ-017 SHALL have port overflow_count, output, 16 bits: count of dropped frames, saturating.

Function
REQ-018 SHALL toggle i2s_clk every CLK_DIV/2 clk cycles while running; a rise strobe and a fall strobe are one-cycle internal pulses.
REQ-019 SHALL advance bit_cnt (0 to 2*SLOT_BITS-1, wrapping) on each fall strobe.
REQ-020 SHALL drive i2s_ws=1 for bit_cnt SLOT_BITS-1 to 2*SLOT_BITS-2, otherwise 0, giving the standard one-bit WS lead.
REQ-021 SHALL sample i2s_sd on the rise strobe; slot bit k (k=0 is MSB, k<DATA_SIZE) is taken at bit_cnt=k for left and at bit_cnt=SLOT_BITS+k for right; other bits are ignored.
REQ-022 SHALL complete a frame at the rise strobe with bit_cnt=2*SLOT_BITS-1.
REQ-023 SHALL discard the frame at completion unless decim_cnt=0; decim_cnt wraps modulo DECIMATE and is cleared on start.
REQ-024 SHALL load the accepted frame into a staging buffer of CHANNELS*REDUCE_FACTOR bytes: top REDUCE_FACTOR bytes of each sample, MSB byte first, left before right.
REQ-025 SHALL run the serializer FSM with states IDLE and SEND: IDLE goes to SEND on the load; SEND holds out_valid=1, advances a byte index when out_valid and out_ready, and returns to IDLE after the out_last byte is accepted.
REQ-026 SHALL assert out_valid on the clk edge after the completing rise strobe, so load latency is 1 cycle.
REQ-027 SHALL hold out_data and out_last stable while out_valid=1 and out_ready=0.
REQ-028 SHALL, when a frame completes while SEND is active, drop the new frame, leave the buffer untouched and increment overflow_count, saturating at 0xFFFF.
REQ-029 SHALL sample enable only in the stopped state or at frame completion.
REQ-030 SHALL, on enable=1 while stopped, start with bit_cnt=0, i2s_ws=0, i2s_clk low and the divider cleared.
REQ-031 SHALL, on enable=0, stop after the current frame completes and is processed; i2s_clk and i2s_ws are then held 0, and an in-flight SEND finishes normally.

Reset
REQ-032 SHALL on rst=0, immediately and asynchronously, force i2s_clk=0, i2s_ws=0, out_valid=0, out_data=0, out_last=0, overflow_count=0, state IDLE, stopped, and all counters 0.
REQ-033 SHALL abandon any partial frame or serialization when reset is asserted mid-operation, with no byte emitted afterwards.

Structure
REQ-034 SHALL place the serializer state enum and the parameter legality checks (elaboration-time assertions) in shared package i2s_pkg.
REQ-035 SHALL implement the divider, bit_cnt, i2s_ws and strobes in sub-module i2s_clkgen, with the capture shift register, staging buffer and serializer in i2s_capture.

Verification
REQ-036 SHALL verify that with CLK_DIV=4, CHANNELS=2 and REDUCE_FACTOR=2, left 0xA5C3F0 and right 0x123456 produce A5, C3, 12, 34, with out_last only on 34.
REQ-037 SHALL verify that with CHANNELS=1 and REDUCE_FACTOR=3, left 0x800001 and any right value produce 80, 00, 01 with out_last on 01.
REQ-038 SHALL verify that with out_ready=0 for 3 frames, the bytes of frame 1 are held, overflow_count=2, and releasing out_ready emits only frame 1.
REQ-039 SHALL verify that with DECIMATE=4, 8 frames emit exactly frames 0 and 4.
REQ-040 SHALL verify that enable falling mid-frame lets that frame emit fully, after which i2s_clk stays 0 for at least 200 cycles.
REQ-041 SHALL verify that rst=0 mid-SEND drops out_valid in the same cycle, with all outputs 0 and overflow_count=0.

Source files
------------

// File: rtl/i2s_pkg.sv
// Shared types and elaboration-time parameter checks for the I2S capture block.
package i2s_pkg;

  // Serializer state: IDLE waits for a staged frame, SEND drains it byte by byte.
  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } ser_state_t;

  // True when the parameter set describes a buildable capture block.
  function automatic bit params_legal(
    input int unsigned clk_div,
    input int unsigned slot_bits,
    input int unsigned data_size,
    input int unsigned reduce_factor,
    input int unsigned channels,
    input int unsigned decimate
  );
    bit ok;
    ok = 1'b1;
    if (clk_div < 4 || (clk_div % 2) != 0) ok = 1'b0;
    if (slot_bits < 8) ok = 1'b0;
    if (data_size < 8 || data_size > slot_bits) ok = 1'b0;
    if (reduce_factor < 1 || reduce_factor > data_size / 8) ok = 1'b0;
    if (channels != 1 && channels != 2) ok = 1'b0;
    if (decimate < 1) ok = 1'b0;
    return ok;
  endfunction

endpackage

// File: rtl/i2s_clkgen.sv
// I2S master timing: bit-clock divider, frame bit counter, word select and
// the one-cycle rise strobe used by the capture logic.
module i2s_clkgen #(
  parameter int unsigned CLK_DIV   = 16,
  parameter int unsigned SLOT_BITS = 32,
  parameter int unsigned CNT_W     = $clog2(2 * SLOT_BITS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  output logic             i2s_clk,
  output logic             i2s_ws,
  output logic             rise,
  output logic [CNT_W-1:0] bit_cnt
);

  localparam int unsigned HALF  = CLK_DIV / 2;
  localparam int unsigned DIV_W = (HALF > 1) ? $clog2(HALF) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(HALF - 1);
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(2 * SLOT_BITS - 1);
  localparam logic [CNT_W-1:0] WS_FIRST = CNT_W'(SLOT_BITS - 1);
  localparam logic [CNT_W-1:0] WS_LAST  = CNT_W'(2 * SLOT_BITS - 2);

  logic [DIV_W-1:0] div_cnt;
  logic             tick;
  logic             fall;
  logic [CNT_W-1:0] bit_nx;
  logic             ws_nx;

  // Half-period tick, edge strobes and the next bit position with its WS decode.
  always_comb begin
    tick   = run && (div_cnt == DIV_LAST);
    rise   = tick && !i2s_clk;
    fall   = tick && i2s_clk;
    bit_nx = (bit_cnt == BIT_LAST) ? '0 : bit_cnt + CNT_W'(1);
    ws_nx  = (bit_nx >= WS_FIRST) && (bit_nx <= WS_LAST);
  end

  // Divider and bit clock; everything returns to zero while not running.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_cnt <= '0;
      i2s_clk <= 1'b0;
    end else if (!run) begin
      div_cnt <= '0;
      i2s_clk <= 1'b0;
    end else if (tick) begin
      div_cnt <= '0;
      i2s_clk <= ~i2s_clk;
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

  // Bit position and word select advance together on the falling bit-clock edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bit_cnt <= '0;
      i2s_ws  <= 1'b0;
    end else if (!run) begin
      bit_cnt <= '0;
      i2s_ws  <= 1'b0;
    end else if (fall) begin
      bit_cnt <= bit_nx;
      i2s_ws  <= ws_nx;
    end
  end

endmodule

// File: rtl/i2s_capture.sv
// I2S master receiver: captures left/right samples, keeps the top bytes of
// each, optionally decimates frames, and streams them out with ready/valid.
module i2s_capture
  import i2s_pkg::*;
#(
  parameter int unsigned CLK_DIV       = 16,
  parameter int unsigned SLOT_BITS     = 32,
  parameter int unsigned DATA_SIZE     = 24,
  parameter int unsigned REDUCE_FACTOR = 2,
  parameter int unsigned CHANNELS      = 2,
  parameter int unsigned DECIMATE      = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  output logic        i2s_clk,
  output logic        i2s_ws,
  input  logic        i2s_sd,
  output logic [7:0]  out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_last,
  output logic [15:0] overflow_count
);

  localparam int unsigned CNT_W  = $clog2(2 * SLOT_BITS);
  localparam int unsigned NBYTES = CHANNELS * REDUCE_FACTOR;
  localparam int unsigned NB8    = NBYTES * 8;
  localparam int unsigned IDX_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam int unsigned DEC_W  = (DECIMATE > 1) ? $clog2(DECIMATE) : 1;

  localparam logic [CNT_W-1:0] BIT_LAST    = CNT_W'(2 * SLOT_BITS - 1);
  localparam logic [CNT_W-1:0] LEFT_LAST   = CNT_W'(DATA_SIZE - 1);
  localparam logic [CNT_W-1:0] RIGHT_FIRST = CNT_W'(SLOT_BITS);
  localparam logic [CNT_W-1:0] RIGHT_LAST  = CNT_W'(SLOT_BITS + DATA_SIZE - 1);
  localparam logic [IDX_W-1:0] IDX_LAST    = IDX_W'(NBYTES - 1);
  localparam logic [DEC_W-1:0] DEC_LAST    = DEC_W'(DECIMATE - 1);

  if (!params_legal(CLK_DIV, SLOT_BITS, DATA_SIZE, REDUCE_FACTOR, CHANNELS, DECIMATE)) begin : g_param_check
    $error("i2s_capture: illegal parameter combination");
  end

  logic                 running;
  logic                 rise;
  logic [CNT_W-1:0]     bit_cnt;
  logic [DATA_SIZE-1:0] left_sh;
  logic [DATA_SIZE-1:0] right_sh;
  logic [DATA_SIZE-1:0] left_nx;
  logic [DATA_SIZE-1:0] right_nx;
  logic                 complete;
  logic                 accept;
  logic                 load;
  logic                 drop;
  logic [DEC_W-1:0]     decim_cnt;
  logic [NB8-1:0]       stage_nx;
  logic [7:0]           stage [NBYTES];
  logic [IDX_W-1:0]     idx;
  ser_state_t           state;
  ser_state_t           state_nx;

  i2s_clkgen #(
    .CLK_DIV   (CLK_DIV),
    .SLOT_BITS (SLOT_BITS),
    .CNT_W     (CNT_W)
  ) u_clkgen (
    .clk     (clk),
    .rst     (rst),
    .run     (running),
    .i2s_clk (i2s_clk),
    .i2s_ws  (i2s_ws),
    .rise    (rise),
    .bit_cnt (bit_cnt)
  );

  // Next shift-register contents; the load uses these so a data bit sampled
  // on the completing strobe (DATA_SIZE == SLOT_BITS) is not lost.
  always_comb begin
    left_nx  = left_sh;
    right_nx = right_sh;
    if (rise) begin
      if (bit_cnt <= LEFT_LAST)
        left_nx = {left_sh[DATA_SIZE-2:0], i2s_sd};
      if (bit_cnt >= RIGHT_FIRST && bit_cnt <= RIGHT_LAST)
        right_nx = {right_sh[DATA_SIZE-2:0], i2s_sd};
    end
  end

  // Frame completion, decimation gate and the load/drop decision.
  always_comb begin
    complete = rise && (bit_cnt == BIT_LAST);
    accept   = complete && (decim_cnt == '0);
    load     = accept && (state == IDLE);
    drop     = accept && (state == SEND);
  end

  // Staging image: top REDUCE_FACTOR bytes of each sample, MSB byte first, left then right.
  for (genvar g = 0; g < REDUCE_FACTOR; g++) begin : g_left_bytes
    assign stage_nx[NB8-1-8*g -: 8] = left_nx[DATA_SIZE-1-8*g -: 8];
  end
  if (CHANNELS == 2) begin : g_right
    for (genvar g = 0; g < REDUCE_FACTOR; g++) begin : g_right_bytes
      assign stage_nx[NB8-1-8*(REDUCE_FACTOR+g) -: 8] = right_nx[DATA_SIZE-1-8*g -: 8];
    end
  end

  // Run control, sample shifting and frame decimation counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      running   <= 1'b0;
      left_sh   <= '0;
      right_sh  <= '0;
      decim_cnt <= '0;
    end else begin
      left_sh  <= left_nx;
      right_sh <= right_nx;
      if (!running) begin
        decim_cnt <= '0;
        if (enable)
          running <= 1'b1;
      end else if (complete) begin
        decim_cnt <= (decim_cnt == DEC_LAST) ? '0 : decim_cnt + DEC_W'(1);
        if (!enable)
          running <= 1'b0;
      end
    end
  end

  // Staging buffer is written only on a load, so a dropped frame leaves it intact.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < NBYTES; i++)
        stage[i] <= '0;
    end else if (load) begin
      for (int unsigned i = 0; i < NBYTES; i++)
        stage[i] <= stage_nx[NB8-1-8*i -: 8];
    end
  end

  // Byte index walks the staging buffer as bytes are accepted.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      idx <= '0;
    else if (load)
      idx <= '0;
    else if (state == SEND && out_ready)
      idx <= (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
  end

  // Serializer state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      state <= IDLE;
    else
      state <= state_nx;
  end

  // Serializer next-state logic.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (load) state_nx = SEND;
      SEND: if (out_ready && idx == IDX_LAST) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Serializer outputs, all zero outside SEND.
  always_comb begin
    out_valid = 1'b0;
    out_data  = '0;
    out_last  = 1'b0;
    if (state == SEND) begin
      out_valid = 1'b1;
      out_data  = stage[idx];
      out_last  = (idx == IDX_LAST);
    end
  end

  // Saturating count of frames dropped because the serializer was busy.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      overflow_count <= '0;
    else if (drop && overflow_count != '1)
      overflow_count <= overflow_count + 16'd1;
  end

endmodule

// File: tb/tb_i2s_capture.sv
// Directed bench for i2s_capture: two configurations, each fed by a small
// I2S transmitter model that follows the DUT's bit clock.
module tb_i2s_capture;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic       a_en = 1'b0, a_ready = 1'b0;
  logic       a_clk, a_ws, a_sd, a_valid, a_last;
  logic [7:0] a_data;
  logic [15:0] a_ovf;

  logic       b_en = 1'b0, b_ready = 1'b0;
  logic       b_clk, b_ws, b_sd, b_valid, b_last;
  logic [7:0] b_data;
  logic [15:0] b_ovf;

  int checks = 0;
  int errors = 0;

  logic [23:0] a_left [16];
  logic [23:0] a_right[16];
  logic [23:0] b_left [16];
  logic [23:0] b_right[16];
  int a_pos = 0, a_frm = 0;
  int b_pos = 0, b_frm = 0;

  logic [8:0] a_got[$];
  logic [8:0] b_got[$];

  always #5 clk = ~clk;

  i2s_capture #(
    .CLK_DIV(4), .SLOT_BITS(32), .DATA_SIZE(24),
    .REDUCE_FACTOR(2), .CHANNELS(2), .DECIMATE(1)
  ) dut_a (
    .clk(clk), .rst(rst), .enable(a_en),
    .i2s_clk(a_clk), .i2s_ws(a_ws), .i2s_sd(a_sd),
    .out_data(a_data), .out_valid(a_valid), .out_ready(a_ready),
    .out_last(a_last), .overflow_count(a_ovf)
  );

  i2s_capture #(
    .CLK_DIV(4), .SLOT_BITS(32), .DATA_SIZE(24),
    .REDUCE_FACTOR(3), .CHANNELS(1), .DECIMATE(4)
  ) dut_b (
    .clk(clk), .rst(rst), .enable(b_en),
    .i2s_clk(b_clk), .i2s_ws(b_ws), .i2s_sd(b_sd),
    .out_data(b_data), .out_valid(b_valid), .out_ready(b_ready),
    .out_last(b_last), .overflow_count(b_ovf)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Slot bit p of a 64-bit frame: 24 MSB-first data bits then zero padding per slot.
  function automatic logic tx_bit(input logic [23:0] l, input logic [23:0] r, input int p);
    if (p < 32) return (p < 24) ? l[23-p] : 1'b0;
    return (p - 32 < 24) ? r[23-(p-32)] : 1'b0;
  endfunction

  assign a_sd = tx_bit(a_left[a_frm % 16], a_right[a_frm % 16], a_pos);
  assign b_sd = tx_bit(b_left[b_frm % 16], b_right[b_frm % 16], b_pos);

  // Transmitter position advances on each falling bit-clock edge.
  always @(negedge a_clk or negedge rst) begin
    if (!rst) a_pos = 0;
    else if (a_pos == 63) begin a_pos = 0; a_frm = a_frm + 1; end
    else a_pos = a_pos + 1;
  end
  always @(negedge b_clk or negedge rst) begin
    if (!rst) b_pos = 0;
    else if (b_pos == 63) begin b_pos = 0; b_frm = b_frm + 1; end
    else b_pos = b_pos + 1;
  end

  // Word select must lead the slot by one bit: high for positions 31..62.
  always @(posedge a_clk) check("ws_a", a_ws, (a_pos >= 31 && a_pos <= 62));
  always @(posedge b_clk) check("ws_b", b_ws, (b_pos >= 31 && b_pos <= 62));

  // Record accepted bytes as {last, data}.
  always @(negedge clk) begin
    if (a_valid && a_ready) a_got.push_back({a_last, a_data});
    if (b_valid && b_ready) b_got.push_back({b_last, b_data});
  end

  task automatic wait_a_valid(input string tag, input int budget);
    int n = 0;
    while (!a_valid && n < budget) begin @(negedge clk); n++; end
    check(tag, a_valid, 1'b1);
  endtask

  task automatic wait_a_bytes(input int n, input int budget);
    int c = 0;
    while (a_got.size() < n && c < budget) begin @(negedge clk); c++; end
  endtask

  initial begin
    logic [8:0] exp1[4];
    logic [8:0] exp2[6];
    logic [8:0] exp3[4];
    logic [7:0] held_data;
    logic       held_last;
    int hi, changes;

    exp1 = '{9'h0A5, 9'h0C3, 9'h012, 9'h134};
    exp2 = '{9'h080, 9'h000, 9'h101, 9'h07F, 9'h000, 9'h1FE};
    exp3 = '{9'h05A, 9'h06B, 9'h07C, 9'h18D};
    for (int i = 0; i < 16; i++) begin
      a_left[i] = '0; a_right[i] = '0;
      b_left[i] = 24'h111111 * i; b_right[i] = 24'hFFFFFF;
    end

    // Reset state
    #5 rst = 1'b0;
    repeat (5) @(negedge clk);
    check("rst_valid", a_valid, 1'b0);
    check("rst_data", a_data, 8'h00);
    check("rst_last", a_last, 1'b0);
    check("rst_ovf", a_ovf, 16'h0000);
    check("rst_i2s_clk", a_clk, 1'b0);
    check("rst_ws", a_ws, 1'b0);
    check("rst_valid_b", b_valid, 1'b0);
    rst = 1'b1;
    repeat (3) @(negedge clk);

    // Two-channel reduce-2 frame, with enable dropped mid-frame
    a_left[0] = 24'hA5C3F0; a_right[0] = 24'h123456;
    @(posedge clk); #1 a_en = 1'b1; a_ready = 1'b1;
    repeat (40) @(posedge clk);
    #1 a_en = 1'b0;
    wait_a_bytes(4, 600);
    check("t1_count", a_got.size(), 4);
    for (int i = 0; i < 4; i++)
      if (i < a_got.size()) check($sformatf("t1_byte%0d", i), a_got[i], exp1[i]);
    hi = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (a_clk) hi++;
    end
    check("t1_clk_idle", hi, 0);
    check("t1_count_after", a_got.size(), 4);

    // One channel, reduce 3, decimate 4: eight frames emit frames 0 and 4
    b_left[0] = 24'h800001; b_left[4] = 24'h7F00FE;
    @(posedge clk); #1 b_ready = 1'b1; b_en = 1'b1;
    repeat (7 * 256 + 100) @(posedge clk);
    #1 b_en = 1'b0;
    repeat (700) @(negedge clk);
    check("t2_count", b_got.size(), 6);
    for (int i = 0; i < 6; i++)
      if (i < b_got.size()) check($sformatf("t2_byte%0d", i), b_got[i], exp2[i]);
    check("t2_ovf", b_ovf, 16'h0000);

    // Backpressure over three frames: first frame held, two dropped
    a_got.delete();
    a_left[1] = 24'h5A6B00; a_right[1] = 24'h7C8D00;
    a_left[2] = 24'h111111; a_right[2] = 24'h222222;
    a_left[3] = 24'h333333; a_right[3] = 24'h444444;
    @(posedge clk); #1 a_ready = 1'b0; a_en = 1'b1;
    wait_a_valid("t3_valid_seen", 400);
    held_data = a_data;
    held_last = a_last;
    changes = 0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (i == 300) a_en = 1'b0;
      if (a_data !== held_data || a_last !== held_last || !a_valid) changes++;
    end
    check("t3_hold", changes, 0);
    check("t3_data", a_data, 8'h5A);
    check("t3_last", a_last, 1'b0);
    check("t3_ovf", a_ovf, 16'd2);
    @(posedge clk); #1 a_ready = 1'b1;
    wait_a_bytes(4, 50);
    repeat (300) @(negedge clk);
    check("t3_count", a_got.size(), 4);
    for (int i = 0; i < 4; i++)
      if (i < a_got.size()) check($sformatf("t3_byte%0d", i), a_got[i], exp3[i]);
    check("t3_ovf_after", a_ovf, 16'd2);

    // Reset asserted mid-SEND
    a_got.delete();
    a_left[4] = 24'hC0FFEE; a_right[4] = 24'hBEEF00;
    @(posedge clk); #1 a_ready = 1'b0; a_en = 1'b1;
    wait_a_valid("t4_valid_seen", 400);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("t4_valid", a_valid, 1'b0);
    check("t4_data", a_data, 8'h00);
    check("t4_last", a_last, 1'b0);
    check("t4_ovf", a_ovf, 16'h0000);
    check("t4_i2s_clk", a_clk, 1'b0);
    check("t4_ws", a_ws, 1'b0);
    a_en = 1'b0;
    a_ready = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (300) @(negedge clk);
    check("t4_no_bytes", a_got.size(), 0);
    check("t4_valid_after", a_valid, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
